// File: rtl/dvi_pkg.sv
// ---------------------------------------------------------------------------
// dvi_pkg
// Shared definitions for the DVI capture controller:
//   - default widths of the pixel (H) and line (V) counters
//   - controller state encoding
// ---------------------------------------------------------------------------
package dvi_pkg;

  localparam int H_W_DEFAULT = 12;
  localparam int V_W_DEFAULT = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_ARMED   = 2'd2,
    ST_CAPTURE = 2'd3
  } dvi_state_t;

endpackage

// File: rtl/dvi_geom_meas.sv
// ---------------------------------------------------------------------------
// dvi_geom_meas
// Measures DE geometry: length of the current DE-high run, length of the last
// completed run, and the number of completed runs (lines) since 'clear'.
// All counters saturate at all-ones; 'sat' is sticky until the next clear.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : restart measurement (frame start)
//   de          : registered data enable
//   de_fall     : DE falling edge (from registered copies)
//   run_cnt     : pixels of the current run so far (0 on the first DE cycle)
//   h_last      : length of the most recently completed run
//   line_cnt    : completed runs since clear
//   sat         : a counter hit its all-ones value since clear
// ---------------------------------------------------------------------------
module dvi_geom_meas #(
  parameter int H_W = 12,
  parameter int V_W = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           de,
  input  logic           de_fall,
  output logic [H_W-1:0] run_cnt,
  output logic [H_W-1:0] h_last,
  output logic [V_W-1:0] line_cnt,
  output logic           sat
);

  localparam logic [H_W-1:0] H_MAX = '1;
  localparam logic [V_W-1:0] V_MAX = '1;

  logic [H_W-1:0] run_cnt_reg;
  logic [H_W-1:0] h_last_reg;
  logic [V_W-1:0] line_cnt_reg;
  logic           sat_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_reg  <= '0;
      h_last_reg   <= '0;
      line_cnt_reg <= '0;
      sat_reg      <= 1'b0;
    end else if (clear) begin
      run_cnt_reg  <= '0;
      h_last_reg   <= '0;
      line_cnt_reg <= '0;
      sat_reg      <= 1'b0;
    end else if (de_fall) begin
      // de is low on a falling edge, so the run restarts from zero here
      run_cnt_reg <= '0;
      h_last_reg  <= run_cnt_reg;
      if (line_cnt_reg == V_MAX) begin
        sat_reg <= 1'b1;
      end else begin
        line_cnt_reg <= line_cnt_reg + 1'b1;
      end
    end else if (de) begin
      if (run_cnt_reg == H_MAX) begin
        sat_reg <= 1'b1;
      end else begin
        run_cnt_reg <= run_cnt_reg + 1'b1;
      end
    end
  end

  assign run_cnt  = run_cnt_reg;
  assign h_last   = h_last_reg;
  assign line_cnt = line_cnt_reg;
  assign sat      = sat_reg;

endmodule

// File: rtl/dvi_capture_ctrl.sv
// ---------------------------------------------------------------------------
// dvi_capture_ctrl
// Measures incoming DVI frame geometry and, on request, streams one frame of
// pixel write strobes with pixel/line coordinates to a frame writer.
//
// Ports:
//   odck_in     : pixel clock (only clock)
//   rst         : asynchronous active-low reset
//   scdt_in     : receiver sync-detect; low forces IDLE
//   de_in       : data enable
//   vsync_in    : vertical sync, active-high
//   capture_req : one-cycle request to capture the next frame
//   locked      : geometry measured and valid
//   h_active    : measured pixels per line
//   v_active    : measured lines per frame
//   wr_en       : pixel write strobe (registered DE while capturing)
//   pix_x       : pixel coordinate of the current wr_en
//   line_y      : line coordinate of the current wr_en
//   frame_done  : one-cycle pulse at the end of a captured frame
//   abort       : one-cycle pulse when a capture is lost
//
// Build option: DVI_CAPTURE_STABLE_CHECK_EN -- when defined, two consecutive
// identical measured frames are needed before locking.
// ---------------------------------------------------------------------------
module dvi_capture_ctrl
  import dvi_pkg::*;
#(
  parameter int H_W = H_W_DEFAULT,
  parameter int V_W = V_W_DEFAULT
) (
  input  logic           odck_in,
  input  logic           rst,
  input  logic           scdt_in,
  input  logic           de_in,
  input  logic           vsync_in,
  input  logic           capture_req,
  output logic           locked,
  output logic [H_W-1:0] h_active,
  output logic [V_W-1:0] v_active,
  output logic           wr_en,
  output logic [H_W-1:0] pix_x,
  output logic [V_W-1:0] line_y,
  output logic           frame_done,
  output logic           abort
);

  dvi_state_t     state_reg, state_next;
  logic           de_reg, de_d_reg, vsync_reg, vsync_d_reg;
  logic           locked_reg, locked_next;
  logic [H_W-1:0] h_active_reg, h_active_next;
  logic [V_W-1:0] v_active_reg, v_active_next;
  logic           frame_done_reg, frame_done_next;
  logic           abort_reg, abort_next;
  logic           pending_reg, pending_next;
  // Set when MEASURE is entered mid-frame: the partial frame must not lock.
  logic           dirty_reg, dirty_next;

  logic           de_fall, vs_rise, frame_ok, lock_now;
  logic [H_W-1:0] run_cnt, h_last;
  logic [V_W-1:0] line_cnt;
  logic           sat;

  assign de_fall = de_d_reg & ~de_reg;
  assign vs_rise = vsync_reg & ~vsync_d_reg;

  // One counter set serves both measuring and the per-line check in CAPTURE;
  // every vsync starts a fresh frame.
  dvi_geom_meas #(.H_W(H_W), .V_W(V_W)) u_meas (
    .clk      (odck_in),
    .rst_n    (rst),
    .clear    (vs_rise),
    .de       (de_reg),
    .de_fall  (de_fall),
    .run_cnt  (run_cnt),
    .h_last   (h_last),
    .line_cnt (line_cnt),
    .sat      (sat)
  );

  assign frame_ok = !dirty_reg && !sat && (h_last != '0) && (line_cnt != '0);

`ifdef DVI_CAPTURE_STABLE_CHECK_EN
  logic [H_W-1:0] cand_h_reg, cand_h_next;
  logic [V_W-1:0] cand_v_reg, cand_v_next;
  logic           cand_valid_reg, cand_valid_next;

  assign lock_now = frame_ok && cand_valid_reg &&
                    (cand_h_reg == h_last) && (cand_v_reg == line_cnt);

  // Candidate geometry from the previous measured frame; any invalid or
  // differing frame restarts the comparison.
  always_comb begin
    cand_h_next     = cand_h_reg;
    cand_v_next     = cand_v_reg;
    cand_valid_next = cand_valid_reg;
    if (!scdt_in || state_reg != ST_MEASURE) begin
      cand_valid_next = 1'b0;
    end else if (vs_rise) begin
      if (frame_ok && !lock_now) begin
        cand_h_next     = h_last;
        cand_v_next     = line_cnt;
        cand_valid_next = 1'b1;
      end else begin
        cand_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge odck_in or negedge rst) begin
    if (!rst) begin
      cand_h_reg     <= '0;
      cand_v_reg     <= '0;
      cand_valid_reg <= 1'b0;
    end else begin
      cand_h_reg     <= cand_h_next;
      cand_v_reg     <= cand_v_next;
      cand_valid_reg <= cand_valid_next;
    end
  end
`else
  assign lock_now = frame_ok;
`endif

  always_comb begin
    state_next      = state_reg;
    locked_next     = locked_reg;
    h_active_next   = h_active_reg;
    v_active_next   = v_active_reg;
    frame_done_next = 1'b0;
    abort_next      = 1'b0;
    pending_next    = pending_reg;
    dirty_next      = vs_rise ? 1'b0 : dirty_reg;

    if (capture_req && state_reg != ST_IDLE) begin
      pending_next = 1'b1;
    end

    if (!scdt_in) begin
      state_next   = ST_IDLE;
      locked_next  = 1'b0;
      pending_next = 1'b0;
      dirty_next   = 1'b0;
      abort_next   = (state_reg == ST_CAPTURE);
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (vs_rise) state_next = ST_MEASURE;
        end
        ST_MEASURE: begin
          if (vs_rise && lock_now) begin
            state_next    = ST_ARMED;
            locked_next   = 1'b1;
            h_active_next = h_last;
            v_active_next = line_cnt;
          end
        end
        ST_ARMED: begin
          if (vs_rise && pending_reg) begin
            state_next   = ST_CAPTURE;
            pending_next = 1'b0;
          end
        end
        ST_CAPTURE: begin
          // A wrong-length line or a vsync before the last line loses the frame.
          if ((de_fall && run_cnt != h_active_reg) || vs_rise) begin
            state_next   = ST_MEASURE;
            locked_next  = 1'b0;
            abort_next   = 1'b1;
            pending_next = 1'b0;
            dirty_next   = !vs_rise;
          end else if (de_fall && line_cnt == v_active_reg - 1'b1) begin
            state_next      = ST_ARMED;
            frame_done_next = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge odck_in or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      de_reg         <= 1'b0;
      de_d_reg       <= 1'b0;
      vsync_reg      <= 1'b0;
      vsync_d_reg    <= 1'b0;
      locked_reg     <= 1'b0;
      h_active_reg   <= '0;
      v_active_reg   <= '0;
      frame_done_reg <= 1'b0;
      abort_reg      <= 1'b0;
      pending_reg    <= 1'b0;
      dirty_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      de_reg         <= de_in;
      de_d_reg       <= de_reg;
      vsync_reg      <= vsync_in;
      vsync_d_reg    <= vsync_reg;
      locked_reg     <= locked_next;
      h_active_reg   <= h_active_next;
      v_active_reg   <= v_active_next;
      frame_done_reg <= frame_done_next;
      abort_reg      <= abort_next;
      pending_reg    <= pending_next;
      dirty_reg      <= dirty_next;
    end
  end

  // Write strobe follows registered DE with no extra delay.
  assign wr_en      = (state_reg == ST_CAPTURE) && de_reg;
  assign pix_x      = (state_reg == ST_CAPTURE) ? run_cnt : '0;
  assign line_y     = (state_reg == ST_CAPTURE) ? line_cnt : '0;
  assign locked     = locked_reg;
  assign h_active   = h_active_reg;
  assign v_active   = v_active_reg;
  assign frame_done = frame_done_reg;
  assign abort      = abort_reg;

endmodule

// File: tb/tb_dvi_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dvi_capture_ctrl
// Drives synthetic DVI frames; expected pixel coordinates are queued while
// DE is driven and popped whenever the controller asserts wr_en.
// ---------------------------------------------------------------------------
module tb_dvi_capture_ctrl;

  localparam int H_W = 12;
  localparam int V_W = 11;
`ifdef DVI_CAPTURE_STABLE_CHECK_EN
  localparam int LOCK_FRAMES = 2;
`else
  localparam int LOCK_FRAMES = 1;
`endif

  logic           odck_in = 1'b0;
  logic           rst = 1'b0;
  logic           scdt_in = 1'b0;
  logic           de_in = 1'b0;
  logic           vsync_in = 1'b0;
  logic           capture_req = 1'b0;
  logic           locked;
  logic [H_W-1:0] h_active;
  logic [V_W-1:0] v_active;
  logic           wr_en;
  logic [H_W-1:0] pix_x;
  logic [V_W-1:0] line_y;
  logic           frame_done;
  logic           abort;

  dvi_capture_ctrl #(.H_W(H_W), .V_W(V_W)) dut (
    .odck_in     (odck_in),
    .rst         (rst),
    .scdt_in     (scdt_in),
    .de_in       (de_in),
    .vsync_in    (vsync_in),
    .capture_req (capture_req),
    .locked      (locked),
    .h_active    (h_active),
    .v_active    (v_active),
    .wr_en       (wr_en),
    .pix_x       (pix_x),
    .line_y      (line_y),
    .frame_done  (frame_done),
    .abort       (abort)
  );

  always #5 odck_in = ~odck_in;

  typedef struct {
    int x;
    int y;
  } pix_t;

  pix_t sb_q[$];
  int   check_cnt = 0;
  int   err_cnt   = 0;
  int   wr_cnt    = 0;
  int   done_cnt  = 0;
  int   abort_cnt = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    check_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge odck_in);
    #1;
  endtask

  task automatic pulse_req();
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
    tick();
  endtask

  // One frame: vsync, then 'lines' DE runs of 'hlen'. The first exp_pix DE
  // cycles are expected as writes. cut_kind 1 drops scdt, 2 asserts reset,
  // after three DE cycles of line cut_line; the task then returns at once.
  task automatic send_frame(input int lines, input int hlen, input int exp_pix,
                            input int cut_line, input int cut_kind);
    int pushed;
    pushed = 0;
    $display("frame: lines=%0d hlen=%0d exp_pix=%0d cut_line=%0d cut_kind=%0d",
             lines, hlen, exp_pix, cut_line, cut_kind);
    vsync_in = 1'b1;
    tick();
    tick();
    vsync_in = 1'b0;
    repeat (3) tick();
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < hlen; p++) begin
        if (l == cut_line && p == 3) begin
          de_in = 1'b0;
          if (cut_kind == 1) scdt_in = 1'b0;
          else rst = 1'b0;
          return;
        end
        de_in = 1'b1;
        if (pushed < exp_pix) begin
          sb_q.push_back('{x: p, y: l});
          pushed++;
        end
        tick();
      end
      de_in = 1'b0;
      repeat (4) tick();
    end
    repeat (4) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_locked"}, int'(locked), 0);
    check_eq({tag, "_h_active"}, int'(h_active), 0);
    check_eq({tag, "_v_active"}, int'(v_active), 0);
    check_eq({tag, "_wr_en"}, int'(wr_en), 0);
    check_eq({tag, "_pix_x"}, int'(pix_x), 0);
    check_eq({tag, "_line_y"}, int'(line_y), 0);
    check_eq({tag, "_frame_done"}, int'(frame_done), 0);
    check_eq({tag, "_abort"}, int'(abort), 0);
  endtask

  // Output monitor, sampled away from the active edge.
  always @(negedge odck_in) begin
    pix_t e;
    if (wr_en) begin
      wr_cnt++;
      if (sb_q.size() == 0) begin
        check_eq("spurious_wr_en", int'(wr_en), 0);
      end else begin
        e = sb_q.pop_front();
        check_eq("pix_x", int'(pix_x), e.x);
        check_eq("line_y", int'(line_y), e.y);
      end
    end
    if (frame_done) done_cnt++;
    if (abort) abort_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b1;
    repeat (3) tick();
    scdt_in = 1'b1;
    repeat (2) tick();

    // Request while IDLE must be dropped
    pulse_req();

    // Lock on 4 lines x 8 pixels
    for (int f = 0; f < LOCK_FRAMES; f++) send_frame(4, 8, 0, -1, 0);
    check_eq("prelock_locked", int'(locked), 0);
    send_frame(4, 8, 0, -1, 0);
    check_eq("lock_locked", int'(locked), 1);
    check_eq("lock_h_active", int'(h_active), 8);
    check_eq("lock_v_active", int'(v_active), 4);
    send_frame(4, 8, 0, -1, 0);
    check_eq("idle_req_ignored_wr", wr_cnt, 0);

    // Capture one frame
    pulse_req();
    send_frame(4, 8, 32, -1, 0);
    check_eq("cap_wr_cnt", wr_cnt, 32);
    check_eq("cap_frame_done", done_cnt, 1);
    check_eq("cap_abort", abort_cnt, 0);
    check_eq("cap_locked", int'(locked), 1);
    send_frame(4, 8, 0, -1, 0);
    check_eq("nocap_wr_cnt", wr_cnt, 32);
    check_eq("nocap_frame_done", done_cnt, 1);

    // Geometry change to 6-pixel lines during capture
    pulse_req();
    send_frame(4, 6, 6, -1, 0);
    check_eq("geom_abort", abort_cnt, 1);
    check_eq("geom_locked", int'(locked), 0);
    check_eq("geom_frame_done", done_cnt, 1);
    for (int f = 0; f < LOCK_FRAMES + 1; f++) send_frame(4, 6, 0, -1, 0);
    check_eq("relock_locked", int'(locked), 1);
    check_eq("relock_h_active", int'(h_active), 6);
    check_eq("relock_v_active", int'(v_active), 4);

    // scdt loss mid-capture: line 0 complete, three pixels of line 1
    pulse_req();
    send_frame(4, 6, 9, 1, 1);
    tick();
    @(negedge odck_in);
    check_eq("scdt_abort", int'(abort), 1);
    check_eq("scdt_wr_en", int'(wr_en), 0);
    check_eq("scdt_locked", int'(locked), 0);
    tick();
    check_eq("scdt_abort_cnt", abort_cnt, 2);
    repeat (3) tick();
    scdt_in = 1'b1;
    tick();
    pulse_req();
    for (int f = 0; f < LOCK_FRAMES + 1; f++) send_frame(4, 8, 0, -1, 0);
    check_eq("scdt_relock", int'(locked), 1);
    check_eq("scdt_relock_h", int'(h_active), 8);
    send_frame(4, 8, 0, -1, 0);
    check_eq("idle_req2_wr_cnt", wr_cnt, 47);

    // Reset mid-capture: line 0 complete, two pixels of line 1 before reset
    pulse_req();
    send_frame(4, 8, 10, 1, 2);
    #1;
    check_all_zero("midrst");
    repeat (6) tick();
    check_eq("midrst_frame_done", done_cnt, 1);
    check_eq("midrst_abort_cnt", abort_cnt, 2);
    rst = 1'b1;
    repeat (3) tick();
    check_eq("sb_drain", sb_q.size(), 0);
    check_eq("total_wr_cnt", wr_cnt, 57);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
